core_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the single-issue integer datapath (fetch → execute → writeback) instead of running it in one combinational cycle. It owns the PC, drives a request/ready handshake to instruction memory, and latches the fetched word into an instruction register that feeds the decoder. It also gates the register-file write enable so writeback happens in exactly one cycle per instruction, and halts on a programmed last PC.

---
 rtl/core_pkg.sv | 23 ++
 rtl/seq_watchdog.sv | 40 ++++
 rtl/core_sequencer.sv | 136 +++++++++++++
 tb/tb_core_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the multi-cycle core sequencer.
//   XLEN             : datapath / address width
//   DEFAULT_RESET_PC : PC loaded on reset and on start unless overridden
//   WDOG_W           : width of the fetch watchdog counter
//   seq_state_t      : sequencer FSM states
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
    localparam int WDOG_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// ---------------------------------------------------------------------------
// seq_watchdog
// Fetch stall counter. Only compiled when CORE_SEQ_TIMEOUT_EN is defined.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   clr    : synchronous clear (held while the sequencer is outside FETCH)
//   inc    : count one stalled fetch cycle
//   tc     : terminal count; high on the stalled cycle that brings the
//            count to LIMIT
// ---------------------------------------------------------------------------
`ifdef CORE_SEQ_TIMEOUT_EN
module seq_watchdog
    import core_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fire on the increment that would make the count equal LIMIT, so the
    // sequencer leaves FETCH after exactly LIMIT stalled cycles.
    assign tc = inc && (cnt == WDOG_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control FSM for the single-issue integer datapath:
// IDLE -> FETCH -> EXEC -> WB -> (FETCH | HALT).
// Optional fetch watchdog enabled by defining CORE_SEQ_TIMEOUT_EN.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : one-cycle pulse, (re)starts from RESET_PC in IDLE/HALT
//   last_pc      : word address of the final instruction
//   imem_req     : fetch request (high for the whole FETCH state)
//   imem_addr    : fetch word address, always equal to pc
//   imem_ready   : memory data valid this cycle
//   imem_rdata   : fetched instruction word
//   instr        : instruction register feeding the decoder
//   rf_we_dec    : decoder write enable
//   rf_we        : register-file write enable, only passes in WB
//   pc           : current PC
//   busy         : in FETCH, EXEC or WB
//   halted       : in HALT
//   fetch_err    : watchdog fired (sticky until reset or start)
//   retired      : number of instructions that completed WB
// ---------------------------------------------------------------------------
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned     TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] last_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    input  logic            rf_we_dec,
    output logic            rf_we,
    output logic [XLEN-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            fetch_err,
    output logic [XLEN-1:0] retired
);

    seq_state_t state;
    logic       wd_tc;
    logic       start_ok;

    assign start_ok = start && ((state == IDLE) || (state == HALT));

`ifdef CORE_SEQ_TIMEOUT_EN
    logic fetch_err_q;

    // Counter is held clear outside FETCH, so every FETCH entry starts at 0.
    seq_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != FETCH),
        .inc   ((state == FETCH) && !imem_ready),
        .tc    (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_err_q <= 1'b0;
        end else if (start_ok) begin
            fetch_err_q <= 1'b0;
        end else if (wd_tc) begin
            fetch_err_q <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign wd_tc          = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc      <= RESET_PC;
                        retired <= '0;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= EXEC;
                    end else if (wd_tc) begin
                        state <= HALT;
                    end
                end
                EXEC: begin
                    state <= WB;
                end
                WB: begin
                    retired <= retired + 32'd1;
                    if (pc == last_pc) begin
                        state <= HALT;
                    end else begin
                        pc    <= pc + 32'd1;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All control outputs decode the state register only; imem_ready never
    // reaches imem_req combinationally.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign busy      = (state == FETCH) || (state == EXEC) || (state == WB);
    assign halted    = (state == HALT);
    assign rf_we     = (state == WB) && rf_we_dec;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] last_pc;
    logic        imem_ready;
    logic        rf_we_dec;

    logic        req0, we0, busy0, halted0, ferr0;
    logic [31:0] addr0, rdata0, instr0, pc0, ret0;
    logic        req1, we1, busy1, halted1, ferr1;
    logic [31:0] addr1, rdata1, instr1, pc1, ret1;

    logic        sel;
    logic        o_req, o_we, o_busy, o_halted, o_ferr;
    logic [31:0] o_addr, o_instr, o_pc, o_ret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: each word is a fixed scramble of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign rdata0 = mem_word(addr0);
    assign rdata1 = mem_word(addr1);

    core_sequencer #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .last_pc(last_pc),
        .imem_req(req0), .imem_addr(addr0), .imem_ready(imem_ready),
        .imem_rdata(rdata0), .instr(instr0), .rf_we_dec(rf_we_dec),
        .rf_we(we0), .pc(pc0), .busy(busy0), .halted(halted0),
        .fetch_err(ferr0), .retired(ret0)
    );

    core_sequencer #(.RESET_PC(32'hFFFF_FFFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .last_pc(last_pc),
        .imem_req(req1), .imem_addr(addr1), .imem_ready(imem_ready),
        .imem_rdata(rdata1), .instr(instr1), .rf_we_dec(rf_we_dec),
        .rf_we(we1), .pc(pc1), .busy(busy1), .halted(halted1),
        .fetch_err(ferr1), .retired(ret1)
    );

    assign o_req    = sel ? req1    : req0;
    assign o_we     = sel ? we1     : we0;
    assign o_busy   = sel ? busy1   : busy0;
    assign o_halted = sel ? halted1 : halted0;
    assign o_ferr   = sel ? ferr1   : ferr0;
    assign o_addr   = sel ? addr1   : addr0;
    assign o_instr  = sel ? instr1  : instr0;
    assign o_pc     = sel ? pc1     : pc0;
    assign o_ret    = sel ? ret1    : ret0;

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sel       = 1'b0;
        rf_we_dec = 1'b1;
        last_pc   = 32'd0;
        do_reset();
        #1;
        checks++;
        if ({req0, busy0, halted0, we0, ferr0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl0 got %b exp 00000", {req0, busy0, halted0, we0, ferr0});
        end
        checks++;
        if ({pc0, addr0, instr0, ret0} !== 128'h0) begin
            errors++;
            $display("FAIL reset_regs0 pc %h addr %h instr %h ret %h exp all 0", pc0, addr0, instr0, ret0);
        end
        checks++;
        if ({req1, busy1, halted1, we1, ferr1} !== 5'b0 || pc1 !== 32'hFFFF_FFFF ||
            addr1 !== 32'hFFFF_FFFF || ret1 !== 32'd0 || instr1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_dut1 ctl %b pc %h addr %h ret %h instr %h exp ctl 0 pc/addr ffffffff",
                     {req1, busy1, halted1, we1, ferr1}, pc1, addr1, ret1, instr1);
        end
        // Without start the sequencer must stay idle whatever memory does.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ready = 1'($urandom);
            #1;
            checks++;
            if ({req0, busy0, halted0, we0} !== 4'b0 || pc0 !== 32'd0) begin
                errors++;
                $display("FAIL idle_hold got ctl %b pc %h exp 0000 pc 0", {req0, busy0, halted0, we0}, pc0);
            end
        end
    endtask

    // Runs one program on the selected DUT and checks every cycle against a
    // timeline model: instruction k starts fetching at t[k], waits waits[k]
    // cycles, then spends one cycle in EXEC and one in WB.
    task automatic run_prog(input string name, input bit use1, input int n,
                            input int waits[8], input bit we_all,
                            input int ign_start_cyc, input bit do_rst);
        int          t[9];
        int          end_c;
        int          k;
        int          phase;
        int          pulses;
        int          exp_pulses;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        logic [31:0] exp_ret;
        logic [31:0] exp_instr;
        bit          instr_known;
        bit          in_fetch;
        bit          exp_halt;
        bit          exp_req;
        bit          exp_we;

        if (do_rst) do_reset();
        sel     = use1;
        rpc     = use1 ? 32'hFFFF_FFFF : 32'h0;
        last_pc = rpc + 32'(n - 1);
        t[0] = 1;
        for (int i = 0; i < n; i++) t[i + 1] = t[i] + waits[i] + 3;
        end_c      = t[n];
        pulses     = 0;
        exp_pulses = 0;

        @(negedge clk);
        start      = 1'b1;
        imem_ready = 1'b0;

        for (int c = 1; c <= end_c + 2; c++) begin
            @(negedge clk);
            start = (c == ign_start_cyc);
            k = 0;
            while (k < n - 1 && c >= t[k + 1]) k++;
            phase     = c - t[k];
            exp_halt  = (c >= end_c);
            in_fetch  = !exp_halt && (phase <= waits[k]);
            exp_req   = in_fetch;
            imem_ready = in_fetch ? (phase == waits[k]) : 1'($urandom);
            rf_we_dec  = we_all ? 1'b1 : 1'($urandom);
            exp_we    = !exp_halt && (phase == waits[k] + 2) && rf_we_dec;
            exp_pc    = exp_halt ? rpc + 32'(n - 1) : rpc + 32'(k);
            exp_ret   = exp_halt ? 32'(n) : 32'(k);
            instr_known = 1'b1;
            if (exp_halt)          exp_instr = mem_word(rpc + 32'(n - 1));
            else if (!in_fetch)    exp_instr = mem_word(rpc + 32'(k));
            else if (k > 0)        exp_instr = mem_word(rpc + 32'(k - 1));
            else begin
                exp_instr   = 32'd0;
                instr_known = 1'b0;
            end
            if (exp_we) exp_pulses++;
            #1;
            if (o_we) pulses++;
            checks++;
            if ({o_req, o_busy, o_halted, o_we, o_ferr} !== {exp_req, !exp_halt, exp_halt, exp_we, 1'b0}) begin
                errors++;
                $display("FAIL %s ctl c%0d got req/busy/halt/we/err %b exp %b", name, c,
                         {o_req, o_busy, o_halted, o_we, o_ferr}, {exp_req, !exp_halt, exp_halt, exp_we, 1'b0});
            end
            checks++;
            if (o_pc !== exp_pc || o_addr !== exp_pc) begin
                errors++;
                $display("FAIL %s pc c%0d got pc %h addr %h exp %h", name, c, o_pc, o_addr, exp_pc);
            end
            checks++;
            if (o_ret !== exp_ret) begin
                errors++;
                $display("FAIL %s retired c%0d got %0d exp %0d", name, c, o_ret, exp_ret);
            end
            if (instr_known) begin
                checks++;
                if (o_instr !== exp_instr) begin
                    errors++;
                    $display("FAIL %s instr c%0d got %h exp %h", name, c, o_instr, exp_instr);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== exp_pulses) begin
            errors++;
            $display("FAIL %s rf_we_pulses got %0d exp %0d", name, pulses, exp_pulses);
        end
    endtask

    task automatic test_basic();
        int w[8] = '{default: 0};
        run_prog("basic", 1'b0, 3, w, 1'b0, -1, 1'b1);
    endtask

    task automatic test_wait_states();
        int w[8] = '{default: 0};
        w[1] = 4;
        run_prog("wait_states", 1'b0, 3, w, 1'b0, -1, 1'b1);
    endtask

    task automatic test_write_gating();
        int w[8] = '{default: 0};
        w[0] = 1;
        w[2] = 2;
        run_prog("write_gating", 1'b0, 3, w, 1'b1, -1, 1'b1);
    endtask

    task automatic test_pc_wrap();
        int w[8] = '{default: 0};
        run_prog("pc_wrap", 1'b1, 3, w, 1'b1, -1, 1'b1);
    endtask

    task automatic test_start_ignored();
        int w[8] = '{default: 0};
        w[1] = 2;
        // Cycle 2 is the EXEC of the first instruction.
        run_prog("start_in_exec", 1'b0, 3, w, 1'b0, 2, 1'b1);
        // Cycle 5 is a stalled FETCH of the second instruction.
        run_prog("start_in_fetch", 1'b0, 3, w, 1'b0, 5, 1'b1);
    endtask

    task automatic test_reset_mid_fetch();
        sel     = 1'b0;
        do_reset();
        last_pc = 32'd5;
        @(negedge clk); start = 1'b1; imem_ready = 1'b0;
        @(negedge clk); start = 1'b0; imem_ready = 1'b1;   // c1 FETCH k0
        @(negedge clk); start = 1'b1;                      // c2 EXEC
        @(negedge clk); start = 1'b0;                      // c3 WB
        @(negedge clk); imem_ready = 1'b0;                 // c4 FETCH k1 stalled
        @(negedge clk);                                    // c5
        #1;
        checks++;
        if (o_req !== 1'b1 || o_addr !== 32'd1 || o_ret !== 32'd1) begin
            errors++;
            $display("FAIL mid_fetch_pre got req %b addr %h ret %0d exp 1 1 1", o_req, o_addr, o_ret);
        end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        checks++;
        if ({o_req, o_busy, o_halted, o_we} !== 4'b0 || o_pc !== 32'd0 || o_ret !== 32'd0 || o_instr !== 32'd0) begin
            errors++;
            $display("FAIL mid_fetch_reset got ctl %b pc %h ret %0d instr %h exp 0",
                     {o_req, o_busy, o_halted, o_we}, o_pc, o_ret, o_instr);
        end
    endtask

    task automatic test_random();
        int w[8];
        int n;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) w[i] = $urandom_range(0, 6);
            // Later runs restart straight from HALT.
            run_prog("random", 1'b0, n, w, 1'b0, -1, it == 0);
        end
    endtask

`ifdef CORE_SEQ_TIMEOUT_EN
    task automatic test_watchdog();
        sel     = 1'b0;
        do_reset();
        last_pc = 32'd3;
        @(negedge clk); start = 1'b1; imem_ready = 1'b0;
        for (int c = 1; c <= 256; c++) begin
            @(negedge clk);
            start      = 1'b0;
            imem_ready = 1'b0;
            #1;
            if (c == 255) begin
                checks++;
                if (o_req !== 1'b1 || o_ferr !== 1'b0 || o_halted !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_before got req %b err %b halt %b exp 1 0 0", o_req, o_ferr, o_halted);
                end
            end
            if (c == 256) begin
                checks++;
                if (o_req !== 1'b0 || o_ferr !== 1'b1 || o_halted !== 1'b1) begin
                    errors++;
                    $display("FAIL wd_fire got req %b err %b halt %b exp 0 1 1", o_req, o_ferr, o_halted);
                end
            end
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        checks++;
        if (o_ferr !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'd0 || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL wd_restart got err %b req %b addr %h halt %b exp 0 1 0 0", o_ferr, o_req, o_addr, o_halted);
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        imem_ready = 1'b0;
        rf_we_dec  = 1'b0;
        last_pc    = 32'd0;
        sel        = 1'b0;
        test_reset();
        test_basic();
        test_wait_states();
        test_write_gating();
        test_pc_wrap();
        test_start_ignored();
        test_reset_mid_fetch();
        test_random();
`ifdef CORE_SEQ_TIMEOUT_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
